// File: rtl/decoder_seq.sv
// Registered binary-to-one-hot decoder with valid/ready commands and a sweep mode.
// Optional feature macro: DECODER_SEQ_RANGE_ERR_EN (err pulse on out-of-range select).
module decoder_seq #(
  parameter int SEL_W   = 3,
  parameter int NUM_OUT = 8,
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [SEL_W-1:0]   in_sel,
  input  logic               in_mode,
  input  logic [DWELL_W-1:0] in_dwell,
  input  logic               abort,
  output logic [NUM_OUT-1:0] y,
  output logic               y_valid,
  output logic               busy,
  output logic               err
);

  // state  | meaning
  // IDLE   | no line driven, ready for a command
  // STATIC | one line held until the next command or abort
  // SWEEP  | walking the line across all outputs, commands blocked
  typedef enum logic [1:0] {IDLE, STATIC, SWEEP} state_t;

  state_t             state, state_nxt;
  logic [SEL_W-1:0]   idx, idx_nxt;
  logic [SEL_W-1:0]   left, left_nxt;
  logic [DWELL_W-1:0] cnt, cnt_nxt;
  logic [DWELL_W-1:0] rld, rld_nxt;
  logic [NUM_OUT-1:0] y_nxt;
  logic               err_nxt;
  logic               accept;
  logic               sel_oor;

  assign accept  = in_valid && in_ready;
  assign sel_oor = {1'b0, in_sel} >= (SEL_W+1)'(NUM_OUT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
      left  <= '0;
      cnt   <= '0;
      rld   <= '0;
      y     <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      left  <= left_nxt;
      cnt   <= cnt_nxt;
      rld   <= rld_nxt;
      y     <= y_nxt;
      err   <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    left_nxt  = left;
    cnt_nxt   = cnt;
    rld_nxt   = rld;
    err_nxt   = 1'b0;
    if (abort) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        SWEEP: begin
          if (cnt == '0) begin
            // left counts positions still to visit after the current one
            if (left == '0) begin
              state_nxt = IDLE;
            end else begin
              idx_nxt  = (idx == SEL_W'(NUM_OUT-1)) ? '0 : idx + SEL_W'(1);
              cnt_nxt  = rld;
              left_nxt = left - SEL_W'(1);
            end
          end else begin
            cnt_nxt = cnt - DWELL_W'(1);
          end
        end
        default: begin
          if (accept) begin
            if (sel_oor) begin
              state_nxt = IDLE;
`ifdef DECODER_SEQ_RANGE_ERR_EN
              err_nxt   = 1'b1;
`endif
            end else if (in_mode) begin
              state_nxt = SWEEP;
              idx_nxt   = in_sel;
              cnt_nxt   = in_dwell;
              rld_nxt   = in_dwell;
              left_nxt  = SEL_W'(NUM_OUT-1);
            end else begin
              state_nxt = STATIC;
              idx_nxt   = in_sel;
            end
          end
        end
      endcase
    end
    y_nxt = (state_nxt == IDLE) ? '0 : ({{(NUM_OUT-1){1'b0}}, 1'b1} << idx_nxt);
  end

  always_comb begin
    in_ready = !abort && (state != SWEEP);
    y_valid  = (state != IDLE);
    busy     = (state == SWEEP);
  end

endmodule
